vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 190 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position, line and frame periods and a lock flag from a sampled VGA hs/vs stream.
// Latency: one clock from a pixel_en sample to rx_x/rx_y/rx_active and every other output.
// Backpressure: none; the decoder follows the pixel_en strobe and never stalls the source.
module vga_sync_decoder #(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        pixel_en,
  input  logic        hs,
  input  logic        vs,
  output logic [10:0] rx_x,
  output logic [10:0] rx_y,
  output logic        rx_active,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic        frame_start,
  output logic        sync_err
);

  localparam int              MW     = $clog2(LOCK_FRAMES + 2);
  localparam logic [MW-1:0]   LOCK_N = MW'(LOCK_FRAMES);
  localparam logic [10:0]     H_OFS  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0]     V_OFS  = 11'(V_SYNC + V_BACK);
  localparam logic [11:0]     H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0]     V_ACT  = 12'(V_ACTIVE);
  localparam logic [10:0]     CNT_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t         state;
  logic           hs_q, vs_q;
  logic [10:0]    hcnt, vcnt;
  logic           h_seen, v_seen;     // an edge has been seen, so the next one closes a period
  logic           h_valid, v_valid;   // h_total / v_total hold a real measurement
  logic           h_mis;              // an h period changed during the current MEASURE frame
  logic [MW-1:0]  match_cnt;

  logic           hs_start, vs_start;
  logic [10:0]    h_meas, v_meas;
  logic [10:0]    hcnt_nxt, vcnt_nxt;
  logic [10:0]    rx_x_nxt, rx_y_nxt;
  logic           timeout;
  logic           h_bad, v_bad;
  logic           frame_ok;
  logic [MW-1:0]  match_inc;
  logic           lock_gain, lock_drop, locked_nxt;

  // Edge detection is gated by pixel_en so nothing downstream moves between samples
  assign hs_start = pixel_en & hs_q & ~hs;
  assign vs_start = pixel_en & vs_q & ~vs;

  assign h_meas   = hcnt + 11'd1;
  assign v_meas   = vcnt + 11'd1;
  assign hcnt_nxt = hs_start ? 11'd0 : ((hcnt == CNT_MAX) ? CNT_MAX : hcnt + 11'd1);
  assign vcnt_nxt = vs_start ? 11'd0 : (hs_start ? vcnt + 11'd1 : vcnt);
  assign rx_x_nxt = hcnt_nxt - H_OFS;
  assign rx_y_nxt = vcnt_nxt - V_OFS;

  // A line that never ends pins hcnt at its ceiling; that is the only way out of a stuck sync
  assign timeout  = pixel_en & (hcnt_nxt == CNT_MAX);

  // Period changes only count once a previous measurement exists to compare against
  assign h_bad    = hs_start & h_valid & (h_meas != h_total);
  assign v_bad    = vs_start & v_valid & (v_meas != v_total);
  assign frame_ok = ~h_mis & ~h_bad & ~v_bad;
  assign match_inc = match_cnt + 1'b1;

  assign lock_gain  = (state == MEASURE) & ~timeout & vs_start & frame_ok & (match_inc >= LOCK_N);
  assign lock_drop  = (state == LOCKED) & (timeout | h_bad | v_bad);
  assign locked_nxt = lock_gain | (locked & ~lock_drop);

  // Sample history, position counters and period measurements
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hcnt    <= '0;
      vcnt    <= '0;
      h_total <= '0;
      v_total <= '0;
      h_seen  <= 1'b0;
      v_seen  <= 1'b0;
      h_valid <= 1'b0;
      v_valid <= 1'b0;
    end else if (pixel_en) begin
      hs_q <= hs;
      vs_q <= vs;
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
      if (hs_start) begin
        h_seen <= 1'b1;
        if (h_seen) begin
          h_total <= h_meas;
          h_valid <= 1'b1;
        end
      end
      if (vs_start) begin
        v_seen <= 1'b1;
        if (v_seen) begin
          v_total <= v_meas;
          v_valid <= 1'b1;
        end
      end
    end
  end

  // Lock FSM: SEARCH waits for a frame boundary, MEASURE counts clean frames, LOCKED watches for drift
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      match_cnt <= '0;
      h_mis     <= 1'b0;
    end else if (pixel_en) begin
      if (timeout) begin
        state  <= SEARCH;
        locked <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (vs_start) begin
              state     <= MEASURE;
              match_cnt <= '0;
              h_mis     <= 1'b0;
            end
          end
          MEASURE: begin
            if (vs_start) begin
              h_mis <= 1'b0;
              if (frame_ok) begin
                match_cnt <= match_inc;
                if (match_inc >= LOCK_N) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end else if (h_bad) begin
              match_cnt <= '0;
              h_mis     <= 1'b1;
            end
          end
          LOCKED: begin
            if (h_bad | v_bad) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered position outputs plus single-clock event pulses
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rx_x        <= '0;
      rx_y        <= '0;
      rx_active   <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_start <= vs_start;
      sync_err    <= lock_drop;
      if (pixel_en) begin
        rx_x      <= rx_x_nxt;
        rx_y      <= rx_y_nxt;
        rx_active <= locked_nxt & ({1'b0, rx_x_nxt} < H_ACT) & ({1'b0, rx_y_nxt} < V_ACT);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder: a small 40x12 sync stream with randomised pixel_en spacing,
// scored against a sample-level reference model; directed checks cover lock, position,
// line-length error, timeout and asynchronous reset.
module tb_vga_sync_decoder;

  localparam int HS_W = 4;      // hsync width, pixels
  localparam int HB   = 3;
  localparam int HA   = 28;
  localparam int VS_W = 1;      // vsync width, lines
  localparam int VB   = 2;
  localparam int VA   = 8;
  localparam int LOCK = 2;
  localparam int HT   = 40;     // stream line length
  localparam int VT   = 12;     // stream frame length
  localparam int HOFS = HS_W + HB;
  localparam int VOFS = VS_W + VB;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
    logic        lk;
    logic [10:0] ht;
    logic [10:0] vt;
    logic        fs;
    logic        se;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel_en;
  logic        hs_in, vs_in;
  logic [10:0] rx_x, rx_y, h_total, v_total;
  logic        rx_active, locked, frame_start, sync_err;

  int tests = 0;
  int fails = 0;
  int se_count = 0;
  int fs_count = 0;
  exp_t q[$];

  // stream position and model state
  int cur_p, cur_l, long_line, gap_fix;
  int m_pix, m_line, m_htot, m_vtot, m_mode, m_good;
  logic m_hs_prev, m_vs_prev, m_hseen, m_vseen, m_hvalid, m_vvalid, m_dirty;

  vga_sync_decoder #(
    .H_SYNC(HS_W), .H_BACK(HB), .H_ACTIVE(HA),
    .V_SYNC(VS_W), .V_BACK(VB), .V_ACTIVE(VA),
    .LOCK_FRAMES(LOCK)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .pixel_en   (pixel_en),
    .hs         (hs_in),
    .vs         (vs_in),
    .rx_x       (rx_x),
    .rx_y       (rx_y),
    .rx_active  (rx_active),
    .locked     (locked),
    .h_total    (h_total),
    .v_total    (v_total),
    .frame_start(frame_start),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rx_x"}, rx_x, 0);
    chk({tag, "_rx_y"}, rx_y, 0);
    chk({tag, "_rx_active"}, rx_active, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_h_total"}, h_total, 0);
    chk({tag, "_v_total"}, v_total, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
  endtask

  task automatic model_reset();
    m_pix = 0; m_line = 0; m_htot = 0; m_vtot = 0; m_mode = 0; m_good = 0;
    m_hs_prev = 1'b1; m_vs_prev = 1'b1;
    m_hseen = 1'b0; m_vseen = 1'b0; m_hvalid = 1'b0; m_vvalid = 1'b0; m_dirty = 1'b0;
  endtask

  // Reference: periods are edge-to-edge sample counts; lock = LOCK consecutive frames
  // whose periods repeat the previous ones (mode 0 search, 1 measure, 2 locked)
  task automatic model_step(input logic hs_v, input logic vs_v, output exp_t e);
    logic hf, vf, hdiff, vdiff, tmo, se;
    int hper, vper, xr, yr;
    hf = m_hs_prev && !hs_v;
    vf = m_vs_prev && !vs_v;
    m_hs_prev = hs_v;
    m_vs_prev = vs_v;
    hper = (m_pix + 1) % 2048;
    vper = (m_line + 1) % 2048;
    hdiff = hf && m_hvalid && (hper != m_htot);
    vdiff = vf && m_vvalid && (vper != m_vtot);
    if (hf && m_hseen) begin m_htot = hper; m_hvalid = 1'b1; end
    if (hf) m_hseen = 1'b1;
    if (vf && m_vseen) begin m_vtot = vper; m_vvalid = 1'b1; end
    if (vf) m_vseen = 1'b1;
    if (hf) m_pix = 0;
    else if (m_pix < 2047) m_pix++;
    if (vf) m_line = 0;
    else if (hf) m_line = (m_line + 1) % 2048;
    tmo = (m_pix == 2047);
    se = 1'b0;
    if (tmo) begin
      se = (m_mode == 2);
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (vf) begin m_mode = 1; m_good = 0; m_dirty = 1'b0; end
    end else if (m_mode == 1) begin
      if (hdiff) begin m_dirty = 1'b1; m_good = 0; end
      if (vf) begin
        if (!m_dirty && !vdiff) m_good++;
        else m_good = 0;
        m_dirty = 1'b0;
        if (m_good >= LOCK) m_mode = 2;
      end
    end else begin
      if (hdiff || vdiff) begin se = 1'b1; m_mode = 0; end
    end
    xr = (m_pix - HOFS) & 2047;
    yr = (m_line - VOFS) & 2047;
    e.x   = 11'(xr);
    e.y   = 11'(yr);
    e.lk  = (m_mode == 2);
    e.act = (m_mode == 2) && (xr < HA) && (yr < VA);
    e.ht  = 11'(m_htot);
    e.vt  = 11'(m_vtot);
    e.fs  = vf;
    e.se  = se;
  endtask

  // Idle gap cycles carry random hs/vs that the DUT must ignore
  task automatic send1(input logic hs_v, input logic vs_v, input int gap);
    exp_t e;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      pixel_en = 1'b0;
      hs_in = 1'($urandom);
      vs_in = 1'($urandom);
    end
    @(negedge clk);
    pixel_en = 1'b1;
    hs_in = hs_v;
    vs_in = vs_v;
    model_step(hs_v, vs_v, e);
    q.push_back(e);
  endtask

  task automatic step();
    int len, gap;
    len = (cur_l == long_line) ? HT + 1 : HT;
    gap = (gap_fix >= 0) ? gap_fix : $urandom_range(0, 2);
    send1((cur_p < HS_W) ? 1'b0 : 1'b1, (cur_l < VS_W) ? 1'b0 : 1'b1, gap);
    cur_p++;
    if (cur_p >= len) begin
      cur_p = 0;
      cur_l = (cur_l + 1) % VT;
    end
  endtask

  task automatic goto_pos(input int tp, input int tl);
    for (int i = 0; i < 4 * HT * VT && !(cur_p == tp && cur_l == tl); i++) step();
  endtask

  task automatic drain();
    @(negedge clk);
    pixel_en = 1'b0;
    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d samples unscored, expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: every pixel_en sample yields one scored response a clock later
  initial begin
    logic pe_s;
    exp_t a, e;
    forever begin
      @(posedge clk);
      pe_s = pixel_en;
      #1;
      if (rst_n) begin
        if (sync_err) se_count++;
        if (frame_start) fs_count++;
        a = '{x: rx_x, y: rx_y, act: rx_active, lk: locked, ht: h_total, vt: v_total,
              fs: frame_start, se: sync_err};
        if (pe_s) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL sb_underflow: DUT response with no expected entry");
          end else begin
            e = q.pop_front();
            if (a !== e) begin
              fails++;
              $display("FAIL sb_sample: got x=%0d y=%0d act=%0b lk=%0b ht=%0d vt=%0d fs=%0b se=%0b, expected x=%0d y=%0d act=%0b lk=%0b ht=%0d vt=%0d fs=%0b se=%0b",
                       a.x, a.y, a.act, a.lk, a.ht, a.vt, a.fs, a.se,
                       e.x, e.y, e.act, e.lk, e.ht, e.vt, e.fs, e.se);
            end
          end
        end else begin
          tests++;
          if (frame_start || sync_err) begin
            fails++;
            $display("FAIL pulse_width: fs=%0b se=%0b on idle cycle, expected 0 0", frame_start, sync_err);
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int se0, fs0;
    rst_n = 1'b0;
    pixel_en = 1'b0;
    hs_in = 1'b1;
    vs_in = 1'b1;
    cur_p = 0; cur_l = 0; long_line = -1; gap_fix = 3;
    model_reset();
    #3;
    chk_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Initial lock, pixel_en every 4th clock: locked rises on the 3rd vs_start
    step();
    goto_pos(0, 0); step(); drain();
    chk("lock_vs2", locked, 0);
    goto_pos(0, 0); step(); drain();
    chk("lock_vs3", locked, 1);
    chk("h_total", h_total, HT);
    chk("v_total", v_total, VT);
    chk("coincident_rx_y", rx_y, 2048 - VOFS);
    gap_fix = -1;

    // Position decode at the corners of the active line
    goto_pos(HOFS, VOFS); step(); drain();
    chk("first_px_x", rx_x, 0);
    chk("first_px_y", rx_y, 0);
    chk("first_px_act", rx_active, 1);
    goto_pos(HOFS + HA - 1, VOFS); step(); drain();
    chk("last_px_x", rx_x, HA - 1);
    chk("last_px_act", rx_active, 1);
    step(); drain();
    chk("past_px_act", rx_active, 0);

    // One line a pixel long drops lock with one sync_err, then relock on the 3rd clean vs_start
    se0 = se_count;
    long_line = 5;
    goto_pos(0, 6); step(); drain();
    long_line = -1;
    chk("long_line_locked", locked, 0);
    chk("long_line_sync_err", se_count - se0, 1);
    goto_pos(0, 0); step();
    goto_pos(0, 0); step(); drain();
    chk("relock_vs2", locked, 0);
    goto_pos(0, 0); step(); drain();
    chk("relock_vs3", locked, 1);

    // Asynchronous reset mid-frame while locked
    goto_pos(15, 4); step(); drain();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_rst");
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fs0 = fs_count;
    goto_pos(0, 0); drain();
    chk("no_fs_before_vs", fs_count - fs0, 0);
    step(); drain();
    chk("fs_at_vs", fs_count - fs0, 1);
    goto_pos(0, 0); step(); drain();
    chk("rst_relock_vs2", locked, 0);
    goto_pos(0, 0); step(); drain();
    chk("rst_relock_vs3", locked, 1);

    // hs stuck high: timeout drops lock once, then no edges keep it searching
    se0 = se_count;
    for (int i = 0; i < 2100; i++) send1(1'b1, 1'b1, 0);
    drain();
    chk("timeout_locked", locked, 0);
    chk("timeout_sync_err", se_count - se0, 1);
    for (int i = 0; i < 200; i++) send1(1'b1, 1'b1, $urandom_range(0, 2));
    drain();
    chk("stuck_locked", locked, 0);
    chk("stuck_sync_err", se_count - se0, 1);

    // Resume: the 2048-pixel line poisons the first compare, so lock lands on the 4th vs_start
    cur_p = 0; cur_l = 0;
    for (int f = 0; f < 3; f++) begin
      step();
      goto_pos(0, 0);
    end
    drain();
    chk("resume_vs3", locked, 0);
    step(); drain();
    chk("resume_vs4", locked, 1);
    chk("resume_h_total", h_total, HT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
